// File: rtl/spi_ram_ctrl_if.sv
// Command/response bus between an SPI slave front-end and the RAM controller.
// The SPI slave drives commands; the controller returns read data and status.
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Byte RAM behind a 10-bit SPI command stream: separate auto-incrementing
// write and read pointers, one-cycle read strobe, sticky protocol error.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t               state;
  logic                 rx_q;
  logic                 rise;
  logic                 pending;
  logic [9:0]           cmd;
  logic [9:0]           pend_cmd;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rd_armed;
  logic [3:0]           op_hot;
  logic                 we;

  logic [7:0] mem [MEM_DEPTH];

  assign rise   = bus.rx_valid & ~rx_q;
  assign op_hot = 4'd1 << cmd[9:8];
  assign we     = (state == EXEC) & op_hot[1] & wr_armed;

  // rst_n gate keeps a write from landing on the edge reset is asserted
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[wr_addr] <= cmd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_q         <= 1'b0;
      pending      <= 1'b0;
      cmd          <= '0;
      pend_cmd     <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_armed     <= 1'b0;
      rd_armed     <= 1'b0;
      bus.dout     <= '0;
      bus.tx_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      rx_q         <= bus.rx_valid;
      bus.tx_valid <= 1'b0;

      // edges seen while busy (or behind an older pending one) queue up
      if (rise && (state != IDLE || pending)) begin
        pending  <= 1'b1;
        pend_cmd <= bus.din;
      end

      unique case (state)
        IDLE: begin
          if (pending) begin
            cmd   <= pend_cmd;
            state <= EXEC;
            if (!rise) begin
              pending <= 1'b0;
            end
          end else if (rise) begin
            cmd   <= bus.din;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= RESP;
          unique case (1'b1)
            op_hot[0]: begin
              wr_addr  <= ADDR_SIZE'(cmd[7:0]);
              wr_armed <= 1'b1;
            end
            op_hot[1]: begin
              if (wr_armed) begin
                wr_addr <= wr_addr + ADDR_SIZE'(1);
              end else begin
                bus.err <= 1'b1;
              end
            end
            op_hot[2]: begin
              rd_addr  <= ADDR_SIZE'(cmd[7:0]);
              rd_armed <= 1'b1;
            end
            op_hot[3]: begin
              if (rd_armed) begin
                bus.dout     <= mem[rd_addr];
                bus.tx_valid <= 1'b1;
                rd_addr      <= rd_addr + ADDR_SIZE'(1);
              end else begin
                bus.err <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
